conv3x3_stream: RTL and testbench

- Streaming 3x3 Gaussian-blur filter for raster-order grayscale pixels, one pixel per clock, no handshake.
- Two internal line buffers, each ROW_SIZE deep, plus a 3x3 window register array form the neighbourhood.
- A fixed-kernel multiply-free adder tree produces one filtered pixel per clock.
- Sits between the image-source stream and downstream CNN/feature stages.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/line_buffer.sv | 41 ++++
 rtl/conv3x3_stream.sv | 86 ++++++++
 tb/tb_conv3x3_stream.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 Gaussian-blur stream filter.
package conv_pkg;

   // Normalisation: the kernel weights sum to 16, so the result is sum >> 4.
   localparam int NORM_SHIFT = 4;

   // Extra sum bits above the pixel width; 16 * max_pixel needs exactly 4 more.
   localparam int SUM_GUARD_BITS = 4;

   // Kernel [1 2 1; 2 4 2; 1 2 1] expressed as left-shift amounts (row 0 = top).
   // Every weight is a power of two, so the adder tree needs no multipliers.
   localparam int KERNEL_SHIFT [3][3] = '{'{0, 1, 0},
                                          '{1, 2, 1},
                                          '{0, 1, 0}};

   // Width of the weighted window sum for a given pixel width.
   function automatic int sum_width(input int word_size);
      return word_size + SUM_GUARD_BITS;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// ROW_SIZE-deep circular delay line: dout is the sample written ROW_SIZE clocks ago.
module line_buffer
   import conv_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE  = 540
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] din,
   output logic [WORD_SIZE-1:0] dout
);

   localparam int PTR_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

   logic [WORD_SIZE-1:0] mem [ROW_SIZE];
   logic [PTR_W-1:0]     ptr;

   // Read-before-write at a single pointer: the slot being overwritten holds the oldest sample.
   assign dout = mem[ptr];

   // Storage and pointer: write the new sample, advance and wrap the pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
         // NOTE: entries are cleared explicitly because a restart must see an all-zero
         // history; this forces a register array rather than an uninitialised RAM.
         for (int i = 0; i < ROW_SIZE; i++) begin
            mem[i] <= '0;
         end
      end else begin
         mem[ptr] <= din;
         if (ptr == PTR_W'(ROW_SIZE - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 Gaussian blur: line buffers -> 3x3 window -> sum register -> output register.
module conv3x3_stream
   import conv_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE  = 540
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] inputPixel,
   output logic [WORD_SIZE-1:0] outputPixel
);

   localparam int SUM_W = sum_width(WORD_SIZE);

   // Row taps: index 0 = top (t-2*ROW_SIZE), 1 = middle (t-ROW_SIZE), 2 = bottom (t).
   logic [WORD_SIZE-1:0] row_tap [3];
   // Window: win[row][col], col 0 = newest sample of that row.
   logic [WORD_SIZE-1:0] win [3][3];
   logic [SUM_W-1:0]     sum_next;
   logic [SUM_W-1:0]     sum_q;

   assign row_tap[2] = inputPixel;

   line_buffer #(
      .WORD_SIZE (WORD_SIZE),
      .ROW_SIZE  (ROW_SIZE)
   ) u_line_mid (
      .clk  (clk),
      .rst  (rst),
      .din  (inputPixel),
      .dout (row_tap[1])
   );

   line_buffer #(
      .WORD_SIZE (WORD_SIZE),
      .ROW_SIZE  (ROW_SIZE)
   ) u_line_top (
      .clk  (clk),
      .rst  (rst),
      .din  (row_tap[1]),
      .dout (row_tap[0])
   );

   // Window shift: each row tap enters column 0 and ages through columns 1 and 2.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else begin
         // NOTE: non-blocking assignments make every column read its neighbour's old
         // value, so the three stages shift together instead of collapsing.
         for (int r = 0; r < 3; r++) begin
            win[r][2] <= win[r][1];
            win[r][1] <= win[r][0];
            win[r][0] <= row_tap[r];
         end
      end
   end

   // Adder tree: power-of-two weights become constant shifts of each window pixel.
   always_comb begin
      // NOTE: the default before the loop guarantees a value on every path, so no latch.
      sum_next = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            sum_next = sum_next + (SUM_W'(win[r][c]) << KERNEL_SHIFT[r][c]);
         end
      end
   end

   // Sum and output registers: normalise by truncating the low NORM_SHIFT bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q       <= '0;
         outputPixel <= '0;
      end else begin
         sum_q       <= sum_next;
         outputPixel <= sum_q[NORM_SHIFT +: WORD_SIZE];
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench: two DUTs (ROW_SIZE 8 and 540) against a history-based kernel model.
module tb_conv3x3_stream;

   localparam int RS_SMALL = 8;
   localparam int RS_BIG   = 540;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_small = 8'd0;
   logic [7:0] in_big = 8'd0;
   logic [7:0] out_small;
   logic [7:0] out_big;

   int checks = 0;
   int failures = 0;

   // Samples accepted since the last reset release, oldest first.
   int hist_small [$];
   int hist_big [$];

   always #5 clk = ~clk;

   conv3x3_stream #(.WORD_SIZE(8), .ROW_SIZE(RS_SMALL)) dut_small (
      .clk         (clk),
      .rst         (rst),
      .inputPixel  (in_small),
      .outputPixel (out_small)
   );

   conv3x3_stream #(.WORD_SIZE(8), .ROW_SIZE(RS_BIG)) dut_big (
      .clk         (clk),
      .rst         (rst),
      .inputPixel  (in_big),
      .outputPixel (out_big)
   );

   function automatic int sample_at(input int which, input int idx);
      if (idx < 0) return 0;
      return (which == 0) ? hist_small[idx] : hist_big[idx];
   endfunction

   // Output after the latest edge: Gaussian kernel on the window whose newest
   // sample is two samples back; anything before reset release counts as zero.
   function automatic int model_out(input int which);
      int rs;
      int newest;
      int sum;
      int w;
      rs = (which == 0) ? RS_SMALL : RS_BIG;
      newest = ((which == 0) ? hist_small.size() : hist_big.size()) - 3;
      sum = 0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            w = ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
            sum += w * sample_at(which, newest - dr * rs - dc);
         end
      end
      return sum / 16;
   endfunction

   // One clock: drive both inputs, take the edge, record history, compare both DUTs.
   task automatic step(input logic [7:0] p_small, input logic [7:0] p_big);
      int e;
      in_small = p_small;
      in_big   = p_big;
      @(posedge clk);
      #1;
      hist_small.push_back(int'(p_small));
      hist_big.push_back(int'(p_big));
      e = model_out(0);
      checks++;
      if (out_small !== 8'(e)) begin
         failures++;
         $display("FAIL model_small edge=%0d got=%0d exp=%0d", hist_small.size() - 1, out_small, e);
      end
      e = model_out(1);
      checks++;
      if (out_big !== 8'(e)) begin
         failures++;
         $display("FAIL model_big edge=%0d got=%0d exp=%0d", hist_big.size() - 1, out_big, e);
      end
   endtask

   // Pulse reset between edges and restart the model from an empty history.
   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      hist_small.delete();
      hist_big.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in_small = 8'hFF;
      in_big   = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_small !== 8'd0 || out_big !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold got=%0d/%0d exp=0", out_small, out_big);
         end
      end
      rst = 1'b1;
      hist_small.delete();
      hist_big.delete();
      // Build up a nonzero output, then assert reset between edges.
      for (int i = 0; i < 2 * RS_SMALL + 5; i++) step(8'hC8, 8'hC8);
      checks++;
      if (out_small !== 8'hC8) begin
         failures++;
         $display("FAIL reset_prefill got=%0d exp=200", out_small);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (out_small !== 8'd0 || out_big !== 8'd0) begin
         failures++;
         $display("FAIL reset_async got=%0d/%0d exp=0", out_small, out_big);
      end
      #1;
      rst = 1'b1;
      hist_small.delete();
      hist_big.delete();
      // History must be gone: zeros in produce zeros out for a full refill.
      for (int i = 0; i < 2 * RS_SMALL + 4; i++) begin
         step(8'd0, 8'd0);
         checks++;
         if (out_small !== 8'd0) begin
            failures++;
            $display("FAIL reset_history got=%0d exp=0", out_small);
         end
      end
   endtask

   task automatic test_constant(input logic [7:0] v);
      do_reset();
      for (int i = 0; i < 2 * RS_SMALL + 10; i++) begin
         step(v, v);
         if (i >= 2 * RS_SMALL + 4) begin
            checks++;
            if (out_small !== v) begin
               failures++;
               $display("FAIL constant v=%0d got=%0d exp=%0d", v, out_small, v);
            end
         end
      end
   endtask

   task automatic test_impulse(input logic [7:0] v);
      int k;
      int centre;
      k = 5;
      centre = (int'(v) * 4) / 16;
      do_reset();
      for (int i = 0; i < 3 * RS_SMALL + 10; i++) begin
         step((i == k) ? v : 8'd0, (i == k) ? v : 8'd0);
         if (i == k + RS_SMALL + 3) begin
            checks++;
            if (out_small !== 8'(centre)) begin
               failures++;
               $display("FAIL impulse_centre v=%0d got=%0d exp=%0d", v, out_small, centre);
            end
         end
         if (i == k + 2 * RS_SMALL + 5) begin
            checks++;
            if (out_small !== 8'd0) begin
               failures++;
               $display("FAIL impulse_tail v=%0d got=%0d exp=0", v, out_small);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 6 * RS_SMALL; i++) begin
         step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
   endtask

   task automatic test_row_wrap();
      int j;
      int n_rows;
      n_rows = 6;
      do_reset();
      for (int i = 0; i < n_rows * RS_BIG; i++) begin
         step(8'(i / RS_SMALL), 8'(i / RS_BIG));
         j = i - 2;
         // Interior window: all three columns from the same rows, centre row index expected.
         if (j >= 2 * RS_BIG && (j % RS_BIG) >= 2) begin
            checks++;
            if (out_big !== 8'(j / RS_BIG - 1)) begin
               failures++;
               $display("FAIL row_interior edge=%0d got=%0d exp=%0d", i, out_big, j / RS_BIG - 1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_constant(8'h64);
      test_constant(8'hFF);
      test_constant(8'h01);
      test_impulse(8'd160);
      test_impulse(8'd15);
      test_random();
      test_row_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
